// File: rtl/wb_stage_pipe_if.sv
// MEM -> WB stage bundle: valid/ready handshake, stall/flush and the registered
// writeback outputs. The slave modport is the stage; the master modport drives it.
interface wb_stage_pipe_if #(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 7,
  parameter int EXC_W   = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 flush;
  logic                 stall;
  logic [WIDTH-1:0]     pc_in;
  logic [WIDTH-1:0]     aluout;
  logic [WIDTH-1:0]     memdata;
  logic [2:0]           mem_read_type;
  logic                 memtoreg;
  logic                 regwrite_in;
  logic [RADDR_W-1:0]   rf_addr_in;
  logic [WIDTH-1:0]     rf_wdata_in;
  logic                 hilo_we_in;
  logic [2*WIDTH-1:0]   hilo_wdata_in;
  logic [EXC_W-1:0]     exception_in;
  logic [WIDTH-1:0]     epc_in;
  logic                 memwrite_in;
  logic                 is_ds_in;

  logic                 out_valid;
  logic                 rf_we;
  logic [RADDR_W-1:0]   rf_addr;
  logic [WIDTH-1:0]     rf_wdata;
  logic                 hilo_we;
  logic [2*WIDTH-1:0]   hilo_wdata;
  logic [WIDTH-1:0]     pc_out;
  logic [EXC_W-1:0]     exception_out;
  logic                 memwrite_out;
  logic                 is_ds_out;

  modport slave (
    input  in_valid, flush, stall, pc_in, aluout, memdata, mem_read_type,
           memtoreg, regwrite_in, rf_addr_in, rf_wdata_in, hilo_we_in,
           hilo_wdata_in, exception_in, epc_in, memwrite_in, is_ds_in,
    output in_ready, out_valid, rf_we, rf_addr, rf_wdata, hilo_we, hilo_wdata,
           pc_out, exception_out, memwrite_out, is_ds_out
  );

  modport master (
    output in_valid, flush, stall, pc_in, aluout, memdata, mem_read_type,
           memtoreg, regwrite_in, rf_addr_in, rf_wdata_in, hilo_we_in,
           hilo_wdata_in, exception_in, epc_in, memwrite_in, is_ds_in,
    input  in_ready, out_valid, rf_we, rf_addr, rf_wdata, hilo_we, hilo_wdata,
           pc_out, exception_out, memwrite_out, is_ds_out
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// Registered writeback stage: load extraction, exception-gated RF/HI-LO writes.
// Optional WB_TRACE_EN adds debug trace ports and a 32-bit retire counter.
module wb_stage_pipe #(
  parameter int WIDTH         = 32,
  parameter int RADDR_W       = 7,
  parameter int EXC_W         = 4,
  parameter int EXC_PASS_CODE = 6
) (
  input  logic             clk,
  input  logic             resetn,
  wb_stage_pipe_if.slave   bus
`ifdef WB_TRACE_EN
  ,
  output logic [WIDTH-1:0] debug_wb_pc,
  output logic [3:0]       debug_wb_rf_wen,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [WIDTH-1:0] debug_wb_rf_wdata,
  output logic [31:0]      debug_retire_cnt
`endif
);

  logic                 valid_r;
  logic [WIDTH-1:0]     pc_r;
  logic [WIDTH-1:0]     wdata_r;
  logic [RADDR_W-1:0]   addr_r;
  logic                 regwrite_r;
  logic                 hilo_we_r;
  logic [2*WIDTH-1:0]   hilo_wdata_r;
  logic [EXC_W-1:0]     exc_r;
  logic [1:0]           epc_low_r;
  logic                 memwrite_r;
  logic                 is_ds_r;

  logic                 accept;
  logic [1:0]           off;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [WIDTH-1:0]     load_data;
  logic [WIDTH-1:0]     next_wdata;
  logic                 exc_none;
  logic                 rf_ok;

  // Only the low address/EPC bits matter here; the rest pass through MEM untouched.
  logic                 unused_bits;
  assign unused_bits = ^{bus.aluout[WIDTH-1:2], bus.epc_in[WIDTH-1:2]};

  assign bus.in_ready = !valid_r || !bus.stall;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  always_comb begin
    off       = bus.aluout[1:0];
    byte_sel  = 8'(bus.memdata >> {off, 3'b000});
    half_sel  = 16'(bus.memdata >> {off[1], 4'b0000});
    load_data = bus.memdata;
    case (bus.mem_read_type)
      3'd1:    load_data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      3'd2:    load_data = {{(WIDTH-8){1'b0}}, byte_sel};
      3'd3:    load_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
      3'd4:    load_data = {{(WIDTH-16){1'b0}}, half_sel};
      default: load_data = bus.memdata;
    endcase
    next_wdata = bus.memtoreg ? load_data : bus.rf_wdata_in;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_r      <= 1'b0;
      pc_r         <= '0;
      wdata_r      <= '0;
      addr_r       <= '0;
      regwrite_r   <= 1'b0;
      hilo_we_r    <= 1'b0;
      hilo_wdata_r <= '0;
      exc_r        <= '0;
      epc_low_r    <= '0;
      memwrite_r   <= 1'b0;
      is_ds_r      <= 1'b0;
    end else if (bus.flush) begin
      valid_r <= 1'b0;
    end else if (bus.stall && valid_r) begin
      valid_r <= valid_r;
    end else if (accept) begin
      valid_r      <= 1'b1;
      pc_r         <= bus.pc_in;
      wdata_r      <= next_wdata;
      addr_r       <= bus.rf_addr_in;
      regwrite_r   <= bus.regwrite_in;
      hilo_we_r    <= bus.hilo_we_in;
      hilo_wdata_r <= bus.hilo_wdata_in;
      exc_r        <= bus.exception_in;
      epc_low_r    <= bus.epc_in[1:0];
      memwrite_r   <= bus.memwrite_in;
      is_ds_r      <= bus.is_ds_in;
    end else begin
      valid_r <= 1'b0;
    end
  end

  // The pass code still commits the RF write, but only for a word-aligned EPC.
  assign exc_none = (exc_r == '0);
  assign rf_ok    = exc_none || ((exc_r == EXC_W'(EXC_PASS_CODE)) && (epc_low_r == 2'b00));

  assign bus.out_valid     = valid_r;
  assign bus.rf_we         = valid_r && regwrite_r && rf_ok;
  assign bus.rf_addr       = addr_r;
  assign bus.rf_wdata      = wdata_r;
  assign bus.hilo_we       = valid_r && hilo_we_r && exc_none;
  assign bus.hilo_wdata    = hilo_wdata_r;
  assign bus.pc_out        = pc_r;
  assign bus.exception_out = exc_r;
  assign bus.memwrite_out  = valid_r && memwrite_r;
  assign bus.is_ds_out     = valid_r && is_ds_r;

`ifdef WB_TRACE_EN
  logic [31:0] retire_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      retire_cnt <= '0;
    end else if (valid_r && !bus.stall) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign debug_wb_pc       = pc_r;
  assign debug_wb_rf_wen   = {4{bus.rf_we}};
  assign debug_wb_rf_wnum  = addr_r[4:0];
  assign debug_wb_rf_wdata = wdata_r;
  assign debug_retire_cnt  = retire_cnt;
`endif

endmodule
